// File: rtl/frame_mux_pkg.sv
// frame_mux_pkg: shared types and constants for frame_source_mux.
// Holds the FSM state enum, a clog2 helper and default parameters.
package frame_mux_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    STREAM,
    FLUSH,
    DRAIN
  } state_e;

  localparam int TIMEOUT_DEF = 1024;
  localparam int FILL_DEF    = 0;

  // Ceiling log2, never below 1 so that every derived width is legal.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/pixel_out_reg.sv
// pixel_out_reg: one-entry ready/valid register stage.
// Ports: in_valid/in_data/in_ready upstream, out_valid/out_data/out_ready down.
module pixel_out_reg #(
  parameter int PIXEL_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [PIXEL_W-1:0] in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [PIXEL_W-1:0] out_data,
  input  logic               out_ready
);

  logic               valid_q, valid_d;
  logic [PIXEL_W-1:0] data_q, data_d;
  logic               load;

  assign in_ready = ~valid_q | out_ready;
  assign load     = in_valid & in_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/frame_source_mux.sv
// frame_source_mux: frame-aligned selector of N_SRC pixel sources.
// Ports: writer start/ack, per-source start/valid/ready/pixel, pixel out.
module frame_source_mux
  import frame_mux_pkg::*;
#(
  parameter int                 N_SRC   = 4,
  parameter int                 PIXEL_W = 8,
  parameter int                 N_PIXEL = 480000,
  parameter int                 TIMEOUT = TIMEOUT_DEF,
  parameter logic [PIXEL_W-1:0] FILL    = PIXEL_W'(FILL_DEF),
  localparam int                SEL_W   = clog2(N_SRC),
  // Counter must represent N_PIXEL itself.
  localparam int                CNT_W   = clog2(N_PIXEL + 1),
  localparam int                TO_W    = clog2(TIMEOUT + 1)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [SEL_W-1:0]           sel,
  input  logic                       start,
  output logic                       start_ack,
  output logic [N_SRC-1:0]           src_start,
  input  logic [N_SRC-1:0]           src_start_ack,
  input  logic [N_SRC*PIXEL_W-1:0]   src_pixel,
  input  logic [N_SRC-1:0]           src_valid,
  output logic [N_SRC-1:0]           src_ready,
  output logic [PIXEL_W-1:0]         pixel,
  output logic                       valid,
  input  logic                       ready,
  output logic [SEL_W-1:0]           active_sel,
  output logic                       frame_done,
  output logic                       underflow,
  output logic                       sel_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_PIXEL - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TO_W-1:0]    stall_q, stall_d;
  logic               uf_q, uf_d;
  logic               serr_q, serr_d;
  logic               done_q, done_d;

  logic [N_SRC-1:0]   sel_oh;
  logic               act_vld;
  logic               act_ack;
  logic [PIXEL_W-1:0] src_pix;
  logic               sel_ok;

  logic               in_valid;
  logic [PIXEL_W-1:0] in_data;
  logic               rdy;

  assign sel_oh  = N_SRC'(1) << sel_q;
  assign act_vld = |(src_valid & sel_oh);
  assign act_ack = |(src_start_ack & sel_oh);
  assign src_pix = src_pixel[PIXEL_W*32'(sel_q) +: PIXEL_W];
  assign sel_ok  = 32'(sel) < N_SRC;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    stall_d   = stall_q;
    uf_d      = uf_q;
    serr_d    = serr_q;
    done_d    = 1'b0;
    start_ack = 1'b0;
    src_start = '0;
    src_ready = '0;
    in_valid  = 1'b0;
    in_data   = src_pix;
    unique case (state_q)
      IDLE: begin
        cnt_d   = '0;
        stall_d = '0;
        if (start) begin
          state_d = REQ;
          if (sel_ok) begin
            sel_d = sel;
          end else begin
            sel_d  = '0;
            serr_d = 1'b1;
          end
        end
      end
      REQ: begin
        src_start = sel_oh;
        if (act_ack) begin
          start_ack = 1'b1;
          state_d   = STREAM;
        end
      end
      STREAM: begin
        src_ready = rdy ? sel_oh : '0;
        in_valid  = act_vld;
        // Acceptance is checked first so a last pixel beats the timeout.
        if (act_vld && rdy) begin
          cnt_d   = cnt_q + 1'b1;
          stall_d = '0;
          if (cnt_q == CNT_LAST) state_d = DRAIN;
        end else if (rdy) begin
          stall_d = stall_q + 1'b1;
          if (stall_q == TO_LAST) begin
            uf_d    = 1'b1;
            stall_d = '0;
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        in_valid = 1'b1;
        in_data  = FILL;
        if (rdy) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (valid && ready) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      stall_q <= '0;
      uf_q    <= 1'b0;
      serr_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      uf_q    <= uf_d;
      serr_q  <= serr_d;
      done_q  <= done_d;
    end
  end

  pixel_out_reg #(
    .PIXEL_W(PIXEL_W)
  ) u_out (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (rdy),
    .out_valid(valid),
    .out_data (pixel),
    .out_ready(ready)
  );

  assign active_sel = sel_q;
  assign frame_done = done_q;
  assign underflow  = uf_q;
  assign sel_err    = serr_q;

endmodule

// File: tb/tb_frame_source_mux.sv
// tb_frame_source_mux: randomized self-checking bench for frame_source_mux.
// Frame-level model: source pixels then FILL, exactly N_PIXEL per frame.
module tb_frame_source_mux;

  localparam int         NP    = 16;
  localparam logic [7:0] FILLV = 8'hAA;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [1:0]  sel = '0;
  logic        start = 1'b0;
  logic        start_ack;
  logic [3:0]  src_start;
  logic [3:0]  src_start_ack = '0;
  logic [31:0] src_pixel = '0;
  logic [3:0]  src_valid = '0;
  logic [3:0]  src_ready;
  logic [7:0]  pixel;
  logic        valid;
  logic        ready = 1'b0;
  logic [1:0]  active_sel;
  logic        frame_done, underflow, sel_err;

  logic [1:0]  sel_b = '0;
  logic        start_b = 1'b0;
  logic        start_ack_b;
  logic [2:0]  src_start_b;
  logic [2:0]  src_start_ack_b = '0;
  logic [23:0] src_pixel_b = '0;
  logic [2:0]  src_valid_b = '0;
  logic [2:0]  src_ready_b;
  logic [7:0]  pixel_b;
  logic        valid_b;
  logic        ready_b = 1'b0;
  logic [1:0]  active_sel_b;
  logic        frame_done_b, underflow_b, sel_err_b;

  frame_source_mux #(
    .N_SRC(4), .PIXEL_W(8), .N_PIXEL(NP),
    .TIMEOUT(8), .FILL(FILLV)
  ) dut (
    .clock(clock), .reset(reset), .sel(sel), .start(start),
    .start_ack(start_ack), .src_start(src_start),
    .src_start_ack(src_start_ack), .src_pixel(src_pixel),
    .src_valid(src_valid), .src_ready(src_ready),
    .pixel(pixel), .valid(valid), .ready(ready),
    .active_sel(active_sel), .frame_done(frame_done),
    .underflow(underflow), .sel_err(sel_err)
  );

  frame_source_mux #(
    .N_SRC(3), .PIXEL_W(8), .N_PIXEL(NP),
    .TIMEOUT(8), .FILL(FILLV)
  ) dut_b (
    .clock(clock), .reset(reset), .sel(sel_b), .start(start_b),
    .start_ack(start_ack_b), .src_start(src_start_b),
    .src_start_ack(src_start_ack_b), .src_pixel(src_pixel_b),
    .src_valid(src_valid_b), .src_ready(src_ready_b),
    .pixel(pixel_b), .valid(valid_b), .ready(ready_b),
    .active_sel(active_sel_b), .frame_done(frame_done_b),
    .underflow(underflow_b), .sel_err(sel_err_b)
  );

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0] out_q[$];
  logic [7:0] exp_q[$];
  int ss_cnt, ack_cnt, ack_cyc, fd_cnt, fd_dly;
  logic [3:0] fd_ss;
  int first_req, first_x, last_x, uf_cyc, last_acc;
  int bad_rdy, bp_err, flush_rdy, act_err;
  int n_out, n_bad, bad_idx;
  logic [7:0] bad_got, bad_exp;
  bit timed_out;

  // Drives one frame from source s and records what the DUT did.
  task automatic run_frame(
    input int s, input int sel_v, input int exp_act,
    input int ack_dly, input int n_send, input int rmode,
    input int gap, input int new_sel, input bit b2b,
    input int stop_after, input bit seq_pix
  );
    logic [7:0] sq[$];
    logic [7:0] p;
    int cyc;
    bit acked, v, uf0;
    int off;
    out_q.delete();
    exp_q.delete();
    ss_cnt = 0; ack_cnt = 0; ack_cyc = -1;
    fd_cnt = 0; fd_dly = -1; fd_ss = 'x;
    first_req = -1; first_x = -1; last_x = -1;
    uf_cyc = -1; last_acc = -1;
    bad_rdy = 0; bp_err = 0; flush_rdy = 0; act_err = 0;
    for (int i = 0; i < n_send; i++) begin
      p = seq_pix ? 8'(i) : 8'($urandom);
      sq.push_back(p);
      if (i < NP) exp_q.push_back(p);
    end
    while (exp_q.size() < NP) exp_q.push_back(FILLV);
    uf0 = underflow;
    cyc = 0; acked = 0; off = 0;
    timed_out = 1;
    while (cyc < 400) begin
      @(negedge clock);
      start = acked ? 1'b0 : 1'b1;
      if (cyc == 0) sel = 2'(sel_v);
      else if (acked && new_sel >= 0) sel = 2'(new_sel);
      src_pixel = $urandom;
      src_valid = 4'($urandom) & ~(4'b0001 << s);
      src_start_ack = 4'($urandom) & ~(4'b0001 << s);
      src_start_ack[s] = !acked && ss_cnt >= ack_dly;
      v = 0;
      if (acked && sq.size() > 0)
        v = (gap == 0) || off >= 3 || ($urandom_range(0, 2) != 0);
      off = v ? 0 : off + 1;
      src_valid[s] = v;
      if (sq.size() > 0) src_pixel[s*8 +: 8] = sq[0];
      case (rmode)
        0: ready = 1'b1;
        1: ready = (cyc % 2) == 0;
        2: ready = $urandom_range(0, 3) != 0;
        default: ready = (cyc % 16) >= 12;
      endcase
      #1;
      if (src_start == (4'b0001 << s) && !acked) begin
        if (first_req < 0) first_req = cyc;
        if (!src_start_ack[s]) ss_cnt++;
      end
      if (start_ack) begin
        ack_cnt++;
        ack_cyc = cyc;
        acked = 1;
      end
      if (first_req >= 0 && active_sel != 2'(exp_act)) act_err++;
      if ((src_ready & ~(4'b0001 << s)) != 0) bad_rdy++;
      if (valid && !ready && src_ready[s]) bp_err++;
      if (underflow && !uf0) begin
        if (uf_cyc < 0) uf_cyc = cyc;
        if (src_ready[s]) flush_rdy++;
      end
      if (src_valid[s] && src_ready[s]) begin
        void'(sq.pop_front());
        last_acc = cyc;
      end
      if (valid && ready) begin
        out_q.push_back(pixel);
        if (first_x < 0) first_x = cyc;
        last_x = cyc;
      end
      if (frame_done) begin
        fd_cnt++;
        fd_dly = cyc - last_x;
        fd_ss = src_start;
        if (b2b) start = 1'b1;
        timed_out = 0;
        break;
      end
      if (stop_after >= 0 && out_q.size() >= stop_after) begin
        timed_out = 0;
        break;
      end
      cyc++;
    end
    n_out = out_q.size();
    n_bad = 0;
    for (int i = 0; i < n_out && i < NP; i++) begin
      if (out_q[i] !== exp_q[i]) begin
        if (n_bad == 0) begin
          bad_idx = i;
          bad_got = out_q[i];
          bad_exp = exp_q[i];
        end
        n_bad++;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    #1;
    n_chk++;
    if ({start_ack, src_start, src_ready, pixel, valid, active_sel,
         frame_done, underflow, sel_err} !== '0)
      $display("FAIL reset_outs_a got nonzero outputs");
    else n_pass++;
    n_chk++;
    if ({start_ack_b, src_start_b, src_ready_b, pixel_b, valid_b,
         active_sel_b, frame_done_b, underflow_b, sel_err_b} !== '0)
      $display("FAIL reset_outs_b got nonzero outputs");
    else n_pass++;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    run_frame(2, 2, 2, 3, NP, 0, 0, -1, 0, -1, 1);
    n_chk++;
    if (timed_out !== 0) $display("FAIL basic_timeout no frame_done");
    else n_pass++;
    n_chk++;
    if (ss_cnt !== 3)
      $display("FAIL basic_src_start got %0d cycles want 3", ss_cnt);
    else n_pass++;
    n_chk++;
    if (ack_cnt !== 1)
      $display("FAIL basic_start_ack got %0d pulses want 1", ack_cnt);
    else n_pass++;
    n_chk++;
    if (first_x - ack_cyc !== 2)
      $display("FAIL basic_latency got %0d want 2", first_x - ack_cyc);
    else n_pass++;
    n_chk++;
    if (n_out !== NP || n_bad !== 0)
      $display("FAIL basic_pixels n=%0d bad=%0d idx=%0d got %h want %h",
               n_out, n_bad, bad_idx, bad_got, bad_exp);
    else n_pass++;
    n_chk++;
    if (last_x - first_x !== NP - 1)
      $display("FAIL basic_rate got span %0d want %0d",
               last_x - first_x, NP - 1);
    else n_pass++;
    n_chk++;
    if (fd_cnt !== 1 || fd_dly !== 1)
      $display("FAIL basic_frame_done cnt=%0d dly=%0d want 1/1",
               fd_cnt, fd_dly);
    else n_pass++;
    n_chk++;
    if (underflow !== 1'b0 || sel_err !== 1'b0)
      $display("FAIL basic_flags uf=%b se=%b want 0/0", underflow, sel_err);
    else n_pass++;
    n_chk++;
    if (bad_rdy !== 0 || act_err !== 0)
      $display("FAIL basic_isolation rdy=%0d act=%0d want 0/0",
               bad_rdy, act_err);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    run_frame(2, 2, 2, 1, NP, 1, 0, -1, 0, -1, 1);
    n_chk++;
    if (n_out !== NP || n_bad !== 0 || fd_cnt !== 1)
      $display("FAIL bp_toggle n=%0d bad=%0d fd=%0d got %h want %h",
               n_out, n_bad, fd_cnt, bad_got, bad_exp);
    else n_pass++;
    n_chk++;
    if (bp_err !== 0)
      $display("FAIL bp_src_ready got %0d bad cycles want 0", bp_err);
    else n_pass++;
    run_frame(1, 1, 1, 2, NP, 3, 1, -1, 0, -1, 0);
    n_chk++;
    if (n_out !== NP || n_bad !== 0 || fd_cnt !== 1)
      $display("FAIL bp_long n=%0d bad=%0d fd=%0d got %h want %h",
               n_out, n_bad, fd_cnt, bad_got, bad_exp);
    else n_pass++;
    n_chk++;
    if (underflow !== 1'b0 || bp_err !== 0)
      $display("FAIL bp_no_stall uf=%b bp=%0d want 0/0", underflow, bp_err);
    else n_pass++;
  endtask

  task automatic test_switch();
    run_frame(0, 0, 0, 0, NP, 2, 1, 3, 1, -1, 0);
    n_chk++;
    if (act_err !== 0 || n_bad !== 0 || n_out !== NP)
      $display("FAIL switch_f1 act=%0d bad=%0d n=%0d want 0/0/%0d",
               act_err, n_bad, n_out, NP);
    else n_pass++;
    n_chk++;
    if (fd_ss !== 4'b0000)
      $display("FAIL switch_gap src_start=%b in done cycle want 0000",
               fd_ss);
    else n_pass++;
    run_frame(3, 3, 3, 2, NP, 2, 1, -1, 0, -1, 0);
    n_chk++;
    if (first_req !== 0)
      $display("FAIL switch_b2b first req cycle %0d want 0", first_req);
    else n_pass++;
    n_chk++;
    if (act_err !== 0 || n_bad !== 0 || n_out !== NP || fd_cnt !== 1)
      $display("FAIL switch_f2 act=%0d bad=%0d n=%0d fd=%0d",
               act_err, n_bad, n_out, fd_cnt);
    else n_pass++;
  endtask

  task automatic test_bad_sel();
    int iso;
    iso = 0;
    @(negedge clock);
    sel_b = 2'd3;
    start_b = 1'b1;
    @(negedge clock);
    start_b = 1'b0;
    #1;
    n_chk++;
    if (sel_err_b !== 1'b1 || active_sel_b !== 2'd0)
      $display("FAIL badsel_latch se=%b act=%0d want 1/0",
               sel_err_b, active_sel_b);
    else n_pass++;
    n_chk++;
    if (src_start_b !== 3'b001)
      $display("FAIL badsel_start got %b want 001", src_start_b);
    else n_pass++;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      src_start_ack_b = 3'($urandom) | 3'b110;
      src_start_ack_b[0] = 1'b0;
      src_valid_b = 3'($urandom) | 3'b110;
      src_pixel_b = 24'($urandom);
      ready_b = 1'b1;
      #1;
      if (start_ack_b || valid_b || src_ready_b != 0) iso++;
    end
    n_chk++;
    if (iso !== 0)
      $display("FAIL badsel_isolation got %0d active cycles want 0", iso);
    else n_pass++;
  endtask

  task automatic test_stall_flush();
    run_frame(1, 1, 1, 1, 5, 0, 0, -1, 0, -1, 0);
    n_chk++;
    if (n_out !== NP || n_bad !== 0)
      $display("FAIL flush_pixels n=%0d bad=%0d idx=%0d got %h want %h",
               n_out, n_bad, bad_idx, bad_got, bad_exp);
    else n_pass++;
    n_chk++;
    if (underflow !== 1'b1 || fd_cnt !== 1)
      $display("FAIL flush_flags uf=%b fd=%0d want 1/1", underflow, fd_cnt);
    else n_pass++;
    n_chk++;
    if (uf_cyc - last_acc !== 9)
      $display("FAIL flush_timeout got %0d cycles want 9",
               uf_cyc - last_acc);
    else n_pass++;
    n_chk++;
    if (flush_rdy !== 0)
      $display("FAIL flush_src_ready got %0d cycles want 0", flush_rdy);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int vis;
    vis = 0;
    run_frame(2, 2, 2, 1, NP, 0, 0, -1, 0, 7, 0);
    #2;
    reset = 1'b0;
    #1;
    n_chk++;
    if ({start_ack, src_start, src_ready, pixel, valid, active_sel,
         frame_done, underflow, sel_err} !== '0)
      $display("FAIL rstmid_outs got nonzero outputs");
    else n_pass++;
    start = 1'b0;
    src_valid = '0;
    src_start_ack = '0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      src_valid = 4'b1111;
      ready = 1'b1;
      #1;
      if (valid || src_ready != 0) vis++;
    end
    n_chk++;
    if (vis !== 0)
      $display("FAIL rstmid_residue got %0d active cycles want 0", vis);
    else n_pass++;
    run_frame(0, 0, 0, 2, NP, 2, 1, -1, 0, -1, 0);
    n_chk++;
    if (n_out !== NP || n_bad !== 0 || fd_cnt !== 1)
      $display("FAIL rstmid_frame n=%0d bad=%0d fd=%0d got %h want %h",
               n_out, n_bad, fd_cnt, bad_got, bad_exp);
    else n_pass++;
    n_chk++;
    if (underflow !== 1'b0 || sel_err !== 1'b0)
      $display("FAIL rstmid_flags uf=%b se=%b want 0/0", underflow, sel_err);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_switch();
    test_bad_sel();
    test_stall_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
